// File: rtl/spree_div_pkg.sv
// Shared constants for the HI/LO divider: state encoding, default width and
// iteration-counter sizing.
package spree_div_pkg;

   localparam int DIV_WIDTH = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   // Counter counts 0..w-1; keep at least one bit for degenerate widths.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/hilo_div_step.sv
// One radix-2 restoring step: shift {remainder, quotient} left, trial-subtract
// the divisor, and keep the difference when it does not go negative.
module hilo_div_step
   import spree_div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic        [WIDTH:0] shifted;
   logic signed [WIDTH:0] trial;

   // Remainder stays below the divisor, so a negative trial implies shifted[WIDTH] == 0.
   always_comb begin
      shifted  = {rem, quo[WIDTH-1]};
      trial    = $signed(shifted) - $signed({1'b0, divisor});
      quo_next = {quo[WIDTH-2:0], ~trial[WIDTH]};
      if (!trial[WIDTH]) begin
         rem_next = trial[WIDTH-1:0];
      end else begin
         rem_next = shifted[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/hilo_divider.sv
// Iterative restoring divider feeding the HI (remainder) / LO (quotient) registers.
// Signed division is available only when HILO_DIV_SIGNED_EN is defined.
module hilo_divider
   import spree_div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic             squashn,
   output logic             stalled,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int               CNT_W     = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] step_cnt;
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] quo_r;
   logic [WIDTH-1:0] dvs_r;
   logic [WIDTH-1:0] raw_a;
   logic             dbz_r;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH-1:0] rem_step;
   logic [WIDTH-1:0] quo_step;
   logic [WIDTH-1:0] fix_q;
   logic [WIDTH-1:0] fix_r;
   logic             accept;

   assign accept  = (state == ST_IDLE) && start && squashn;
   assign stalled = accept || (state == ST_BUSY) || (state == ST_FIX);

`ifdef HILO_DIV_SIGNED_EN
   logic q_neg;
   logic r_neg;

   function automatic logic signed [WIDTH-1:0] negate(input logic signed [WIDTH-1:0] v);
      return -v;
   endfunction

   // The most-negative value negates to itself, which is its correct unsigned magnitude.
   always_comb begin
      mag_a = (is_signed && opA[WIDTH-1]) ? negate(opA) : opA;
      mag_b = (is_signed && opB[WIDTH-1]) ? negate(opB) : opB;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         q_neg <= is_signed && (opA[WIDTH-1] ^ opB[WIDTH-1]);
         r_neg <= is_signed && opA[WIDTH-1];
      end
   end

   always_comb begin
      fix_q = q_neg ? negate(quo_r) : quo_r;
      fix_r = r_neg ? negate(rem_r) : rem_r;
   end
`else
   logic unused_is_signed;

   assign unused_is_signed = is_signed;
   assign mag_a            = opA;
   assign mag_b            = opB;
   assign fix_q            = quo_r;
   assign fix_r            = rem_r;
`endif

   hilo_div_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .rem     (rem_r),
      .quo     (quo_r),
      .divisor (dvs_r),
      .rem_next(rem_step),
      .quo_next(quo_step)
   );

   // Operand capture at the start edge, then one step per BUSY cycle.
   always_ff @(posedge clk) begin
      if (accept) begin
         rem_r <= '0;
         quo_r <= mag_a;
         dvs_r <= mag_b;
         raw_a <= opA;
         dbz_r <= (opB == '0);
      end else if (state == ST_BUSY) begin
         rem_r <= rem_step;
         quo_r <= quo_step;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         step_cnt    <= '0;
         done        <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!squashn) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start) begin
                     state    <= ST_BUSY;
                     step_cnt <= '0;
                  end
               end
               ST_BUSY: begin
                  if (step_cnt == LAST_STEP) begin
                     state <= ST_FIX;
                  end
                  step_cnt <= step_cnt + CNT_W'(1);
               end
               ST_FIX: begin
                  // Divide by zero reports all-ones quotient and the untouched dividend.
                  state       <= ST_IDLE;
                  done        <= 1'b1;
                  lo          <= dbz_r ? '1 : fix_q;
                  hi          <= dbz_r ? raw_a : fix_r;
                  div_by_zero <= dbz_r;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hilo_divider.sv
// Directed-vector bench for hilo_divider (WIDTH=32); signed expectations follow
// whether HILO_DIV_SIGNED_EN is defined.
module tb_hilo_divider;

   logic        clk;
   logic        reset;
   logic        start;
   logic        is_signed;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        squashn;
   logic        stalled;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_by_zero;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef HILO_DIV_SIGNED_EN
   localparam logic [31:0] EXP_M7_LO  = 32'hFFFF_FFFD;
   localparam logic [31:0] EXP_M7_HI  = 32'hFFFF_FFFF;
   localparam logic [31:0] EXP_7N_LO  = 32'hFFFF_FFFD;
   localparam logic [31:0] EXP_7N_HI  = 32'h0000_0001;
   localparam logic [31:0] EXP_OVF_LO = 32'h8000_0000;
   localparam logic [31:0] EXP_OVF_HI = 32'h0000_0000;
`else
   localparam logic [31:0] EXP_M7_LO  = 32'h7FFF_FFFC;
   localparam logic [31:0] EXP_M7_HI  = 32'h0000_0001;
   localparam logic [31:0] EXP_7N_LO  = 32'h0000_0000;
   localparam logic [31:0] EXP_7N_HI  = 32'h0000_0007;
   localparam logic [31:0] EXP_OVF_LO = 32'h0000_0000;
   localparam logic [31:0] EXP_OVF_HI = 32'h8000_0000;
`endif

   hilo_divider #(
      .WIDTH(32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .is_signed  (is_signed),
      .opA        (op_a),
      .opB        (op_b),
      .squashn    (squashn),
      .stalled    (stalled),
      .done       (done),
      .hi         (hi),
      .lo         (lo),
      .div_by_zero(div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues start in the current cycle (cycle 0) and returns in the done cycle.
   task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         output int dcyc, output logic [31:0] q, output logic [31:0] r,
                         output logic z, output bit stall_ok);
      dcyc     = -1;
      q        = '0;
      r        = '0;
      z        = 1'b0;
      stall_ok = 1'b1;
      start     = 1'b1;
      op_a      = a;
      op_b      = b;
      is_signed = sgn;
      #1;
      if (stalled !== 1'b1) stall_ok = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         tick();
         start     = 1'b0;
         op_a      = ~a;
         op_b      = b + 32'd1;
         is_signed = ~sgn;
         #1;
         if (done === 1'b1) begin
            dcyc = c;
            q    = lo;
            r    = hi;
            z    = div_by_zero;
            if (stalled !== 1'b0) stall_ok = 1'b0;
            break;
         end
         if (stalled !== 1'b1) stall_ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
      n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
      n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
      n_checks++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL reset_stalled: got %b want 0", stalled); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_unsigned();
      int dc; logic [31:0] q; logic [31:0] r; logic z; bit sok;
      do_div(32'd100, 32'd7, 1'b0, dc, q, r, z, sok);
      n_checks++; if (dc !== 34) begin n_fail++; $display("FAIL u100_7_latency: got %0d want 34", dc); end
      n_checks++; if (q !== 32'd14) begin n_fail++; $display("FAIL u100_7_lo: got %0d want 14", q); end
      n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL u100_7_hi: got %0d want 2", r); end
      n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL u100_7_dbz: got %b want 0", z); end
      n_checks++; if (sok !== 1'b1) begin n_fail++; $display("FAIL u100_7_stalled: got %b want 1", sok); end
      tick();
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse_width: got %b want 0", done); end
      do_div(32'd5, 32'd9, 1'b0, dc, q, r, z, sok);
      n_checks++; if (q !== 32'd0 || r !== 32'd5) begin n_fail++; $display("FAIL u5_9: got lo=%0d hi=%0d want lo=0 hi=5", q, r); end
      do_div(32'hFFFF_FFF9, 32'd2, 1'b0, dc, q, r, z, sok);
      n_checks++; if (q !== 32'h7FFF_FFFC || r !== 32'd1) begin n_fail++; $display("FAIL uFFFFFFF9_2: got lo=%h hi=%h want lo=7ffffffc hi=1", q, r); end
   endtask

   task automatic test_signed();
      int dc; logic [31:0] q; logic [31:0] r; logic z; bit sok;
      do_div(32'hFFFF_FFF9, 32'd2, 1'b1, dc, q, r, z, sok);
      n_checks++; if (q !== EXP_M7_LO) begin n_fail++; $display("FAIL sm7_2_lo: got %h want %h", q, EXP_M7_LO); end
      n_checks++; if (r !== EXP_M7_HI) begin n_fail++; $display("FAIL sm7_2_hi: got %h want %h", r, EXP_M7_HI); end
      n_checks++; if (dc !== 34) begin n_fail++; $display("FAIL sm7_2_latency: got %0d want 34", dc); end
      do_div(32'd7, 32'hFFFF_FFFE, 1'b1, dc, q, r, z, sok);
      n_checks++; if (q !== EXP_7N_LO || r !== EXP_7N_HI) begin n_fail++; $display("FAIL s7_m2: got lo=%h hi=%h want lo=%h hi=%h", q, r, EXP_7N_LO, EXP_7N_HI); end
   endtask

   task automatic test_div_zero();
      int dc; logic [31:0] q; logic [31:0] r; logic z; bit sok;
      for (int s = 0; s < 2; s++) begin
         do_div(32'd5, 32'd0, s[0], dc, q, r, z, sok);
         n_checks++; if (q !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dbz_lo sgn=%0d: got %h want ffffffff", s, q); end
         n_checks++; if (r !== 32'd5) begin n_fail++; $display("FAIL dbz_hi sgn=%0d: got %h want 5", s, r); end
         n_checks++; if (z !== 1'b1) begin n_fail++; $display("FAIL dbz_flag sgn=%0d: got %b want 1", s, z); end
         n_checks++; if (dc !== 34) begin n_fail++; $display("FAIL dbz_latency sgn=%0d: got %0d want 34", s, dc); end
      end
   endtask

   task automatic test_overflow();
      int dc; logic [31:0] q; logic [31:0] r; logic z; bit sok;
      do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, dc, q, r, z, sok);
      n_checks++; if (q !== EXP_OVF_LO) begin n_fail++; $display("FAIL ovf_lo: got %h want %h", q, EXP_OVF_LO); end
      n_checks++; if (r !== EXP_OVF_HI) begin n_fail++; $display("FAIL ovf_hi: got %h want %h", r, EXP_OVF_HI); end
      n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL ovf_dbz: got %b want 0", z); end
   endtask

   task automatic test_squash();
      int dc; logic [31:0] q; logic [31:0] r; logic z; bit sok;
      bit seen_done;
      do_div(32'd100, 32'd7, 1'b0, dc, q, r, z, sok);
      n_checks++; if (q !== 32'd14) begin n_fail++; $display("FAIL squash_pre_lo: got %0d want 14", q); end
      start = 1'b1; op_a = 32'd1000; op_b = 32'd3; is_signed = 1'b0;
      seen_done = 1'b0;
      for (int c = 1; c <= 10; c++) begin
         tick();
         start = 1'b0;
         if (c == 10) squashn = 1'b0;
         #1;
         if (done === 1'b1) seen_done = 1'b1;
      end
      tick();
      squashn = 1'b1; start = 1'b1; op_a = 32'd200; op_b = 32'd6;
      #1;
      n_checks++; if (seen_done !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL squash_no_done: got %b want 0", seen_done | done); end
      n_checks++; if (hi !== 32'd2 || lo !== 32'd14) begin n_fail++; $display("FAIL squash_hold: got hi=%0d lo=%0d want hi=2 lo=14", hi, lo); end
      n_checks++; if (stalled !== 1'b1) begin n_fail++; $display("FAIL squash_restart_stall: got %b want 1", stalled); end
      dc = -1;
      for (int c = 12; c <= 80; c++) begin
         tick();
         start = (c == 20);
         if (c == 20) begin op_a = 32'd9; op_b = 32'd1; end
         #1;
         if (done === 1'b1) begin dc = c; break; end
      end
      n_checks++; if (dc !== 45) begin n_fail++; $display("FAIL squash_restart_cycle: got %0d want 45", dc); end
      n_checks++; if (lo !== 32'd33 || hi !== 32'd2) begin n_fail++; $display("FAIL squash_restart_result: got lo=%0d hi=%0d want lo=33 hi=2", lo, hi); end
      start = 1'b0;
   endtask

   task automatic test_reset_mid();
      int dc; logic [31:0] q; logic [31:0] r; logic z; bit sok;
      start = 1'b1; op_a = 32'd100; op_b = 32'd7; is_signed = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         start = 1'b0;
         if (c == 20) reset = 1'b1;
      end
      tick();
      reset = 1'b0;
      #1;
      n_checks++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL midreset_hilo: got hi=%h lo=%h want 0", hi, lo); end
      n_checks++; if (done !== 1'b0 || div_by_zero !== 1'b0) begin n_fail++; $display("FAIL midreset_flags: got done=%b dbz=%b want 0", done, div_by_zero); end
      n_checks++; if (stalled !== 1'b0) begin n_fail++; $display("FAIL midreset_idle: got stalled=%b want 0", stalled); end
      do_div(32'd100, 32'd7, 1'b0, dc, q, r, z, sok);
      n_checks++; if (dc !== 34 || q !== 32'd14 || r !== 32'd2) begin n_fail++; $display("FAIL midreset_next: got cyc=%0d lo=%0d hi=%0d want 34/14/2", dc, q, r); end
   endtask

   task automatic test_back_to_back();
      int dc; logic [31:0] q; logic [31:0] r; logic z; bit sok;
      do_div(32'h1234_5678, 32'h0000_1234, 1'b0, dc, q, r, z, sok);
      n_checks++; if (q !== 32'h0001_0004 || r !== 32'h0000_0DA8) begin n_fail++; $display("FAIL b2b_first: got lo=%h hi=%h want lo=00010004 hi=00000da8", q, r); end
      do_div(32'hFFFF_FFFF, 32'h0000_0010, 1'b0, dc, q, r, z, sok);
      n_checks++; if (dc !== 34) begin n_fail++; $display("FAIL b2b_latency: got %0d want 34", dc); end
      n_checks++; if (q !== 32'h0FFF_FFFF || r !== 32'h0000_000F) begin n_fail++; $display("FAIL b2b_second: got lo=%h hi=%h want lo=0fffffff hi=0000000f", q, r); end
      n_checks++; if (sok !== 1'b1 || z !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_dbz: got stall_ok=%b dbz=%b want 1/0", sok, z); end
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      is_signed = 1'b0;
      op_a      = '0;
      op_b      = '0;
      squashn   = 1'b1;
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_overflow();
      test_squash();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
